// File: rtl/inv_trig_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inv_trig_unit_pkg
//  Description : Shared definitions for the inverse-trigonometry unit:
//                operand width, BF16 angle constants, mode codes, FSM state
//                encoding and the CORDIC atan angle table (degrees, 10
//                fractional bits).
//  Revision    : 1.0 - initial release
// ============================================================================
package inv_trig_unit_pkg;

  localparam int INPUTOUTBIT   = 16;
  localparam int A_LIMIT       = 999;   // largest legal operand magnitude
  localparam int ATAN_TAB_LEN  = 12;
  localparam int ATAN_TAB_FRAC = 10;    // fractional bits the table is built for

  // BF16 angle constants (degrees)
  localparam logic [15:0] BF16_ZERO = 16'h0000;
  localparam logic [15:0] BF16_P45  = 16'h4234;
  localparam logic [15:0] BF16_P90  = 16'h42B4;
  localparam logic [15:0] BF16_N90  = 16'hC2B4;
  localparam logic [15:0] BF16_P180 = 16'h4334;
  localparam logic [15:0] BF16_NAN  = 16'hFFC0;

  typedef enum logic [1:0] {
    MODE_ASIN = 2'd0,
    MODE_ACOS = 2'd1,
    MODE_ATAN = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_PACK = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // round(atan(2^-i) * 180/pi * 2^10); entries past the table read as zero
  function automatic logic [16:0] atan_deg(input logic [3:0] idx);
    logic [16:0] val;
    case (idx)
      4'd0:    val = 17'd46080;
      4'd1:    val = 17'd27203;
      4'd2:    val = 17'd14373;
      4'd3:    val = 17'd7296;
      4'd4:    val = 17'd3662;
      4'd5:    val = 17'd1833;
      4'd6:    val = 17'd917;
      4'd7:    val = 17'd458;
      4'd8:    val = 17'd229;
      4'd9:    val = 17'd115;
      4'd10:   val = 17'd57;
      4'd11:   val = 17'd29;
      default: val = 17'd0;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_trig_unit_fx_to_bf16.sv
`default_nettype none
// ============================================================================
//  Module      : fx_to_bf16
//  Description : Combinational unsigned fixed-point magnitude to BF16 packer.
//                Leading-one normalisation, round-to-nearest-even to 7
//                mantissa bits, renormalisation on rounding carry-out.
//                A zero magnitude always yields +0 regardless of sign.
//  Ports       : mag_i  - unsigned magnitude, FRAC fractional bits
//                sign_i - sign to apply to a non-zero result
//                bf16_o - packed BF16 value
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_to_bf16 #(
  parameter int MAG_W = 17,
  parameter int FRAC  = 10
) (
  input  logic [MAG_W-1:0] mag_i,
  input  logic             sign_i,
  output logic [15:0]      bf16_o
);

  // Nine zero bits below the input guarantee mantissa, guard and sticky
  // positions exist for any MAG_W.
  localparam int XW = MAG_W + 9;
  localparam int SW = $clog2(XW) + 1;
  localparam logic [7:0] EXP_OFS = 8'(127 - FRAC);

  logic [SW-1:0] lead;
  logic [SW-1:0] shamt;
  logic [XW-1:0] norm;
  logic [6:0]    mant;
  logic          guard;
  logic          sticky;
  logic          rnd_up;
  logic [7:0]    mant_r;
  logic [7:0]    exp_b;

  always_comb begin
    lead = '0;
    for (int k = 0; k < MAG_W; k++) begin
      if (mag_i[k]) lead = SW'(k);
    end
    shamt  = SW'(MAG_W - 1) - lead;
    norm   = {mag_i, 9'd0} << shamt;          // leading one lands on bit XW-1
    mant   = norm[XW-2 -: 7];
    guard  = norm[XW-9];
    sticky = |norm[XW-10:0];
    rnd_up = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {7'd0, rnd_up};
    // A carry-out leaves mant_r[6:0] all zero, so only the exponent moves.
    exp_b  = EXP_OFS + 8'(lead) + {7'd0, mant_r[7]};
    if (mag_i == '0) begin
      bf16_o = 16'h0000;
    end else begin
      bf16_o = {sign_i, exp_b, mant_r[6:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/inv_trig_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inv_trig_unit
//  Description : Multi-cycle asin/acos/atan unit. Integer operand in, BF16
//                angle in degrees out. asin/acos resolve -1/0/1 directly;
//                atan runs a vectoring-mode CORDIC over ITER cycles.
//  Ports       : clk, rst_n (async, active low)
//                start  - level request, sampled in IDLE
//                mode   - 0 asin, 1 acos, 2 atan, 3 reserved
//                a      - signed integer operand, legal [-999, 999]
//                result - BF16 angle; error - NaN/illegal flag
//                done   - result valid; busy - LOAD..PACK in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_trig_unit
  import inv_trig_unit_pkg::*;
#(
  parameter int ITER     = 12,
  parameter int ANG_FRAC = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic signed [INPUTOUTBIT-1:0] a,
  output logic [15:0]                   result,
  output logic                          error,
  output logic                          done,
  output logic                          busy
);

  localparam int XYW = INPUTOUTBIT + ITER + 2;
  localparam int ZW  = 7 + ANG_FRAC + 1;
  localparam logic signed [XYW-1:0] XY_ONE = XYW'(64'd1 << ITER);
  localparam logic signed [ZW-1:0]  Z_MAX  = ZW'(64'd90 << ANG_FRAC);

  state_e                  state_q;
  logic signed [XYW-1:0]   x_q, y_q;
  logic signed [ZW-1:0]    z_q;
  logic [3:0]              iter_q;
  logic                    neg_q;
  logic [INPUTOUTBIT-1:0]  abs_q;
  logic [15:0]             result_q;
  logic                    error_q, done_q, busy_q;

  logic [INPUTOUTBIT-1:0]  abs_a;
  logic                    a_legal, a_small, a_zero;
  logic [15:0]             small_res;
  logic [16:0]             tab_raw;
  logic signed [ZW-1:0]    tab_val;
  logic [ZW-2:0]           z_mag;
  logic [15:0]             packed_res;

  assign abs_a   = a[INPUTOUTBIT-1] ? INPUTOUTBIT'(-a) : INPUTOUTBIT'(a);
  assign a_legal = (a >= -INPUTOUTBIT'(A_LIMIT)) && (a <= INPUTOUTBIT'(A_LIMIT));
  assign a_small = (abs_a <= INPUTOUTBIT'(1));
  assign a_zero  = (a == '0);

  // Direct asin/acos answers for the only defined integer inputs.
  always_comb begin
    small_res = BF16_ZERO;
    if (mode_e'(mode) == MODE_ASIN) begin
      if (a_zero)                small_res = BF16_ZERO;
      else if (a[INPUTOUTBIT-1]) small_res = BF16_N90;
      else                       small_res = BF16_P90;
    end else begin
      if (a_zero)                small_res = BF16_P90;
      else if (a[INPUTOUTBIT-1]) small_res = BF16_P180;
      else                       small_res = BF16_ZERO;
    end
  end

  assign tab_raw = atan_deg(iter_q);

  // The table is built for ATAN_TAB_FRAC fractional bits; rescale to ANG_FRAC.
  generate
    if (ANG_FRAC >= ATAN_TAB_FRAC) begin : g_tab_up
      assign tab_val = ZW'(tab_raw) << (ANG_FRAC - ATAN_TAB_FRAC);
    end else begin : g_tab_dn
      assign tab_val = ZW'(tab_raw >> (ATAN_TAB_FRAC - ANG_FRAC));
    end
  endgenerate

  // Residual CORDIC error can push z slightly outside [0, 90 deg].
  always_comb begin
    if (z_q[ZW-1])        z_mag = '0;
    else if (z_q > Z_MAX) z_mag = Z_MAX[ZW-2:0];
    else                  z_mag = z_q[ZW-2:0];
  end

  fx_to_bf16 #(
    .MAG_W (ZW - 1),
    .FRAC  (ANG_FRAC)
  ) u_pack (
    .mag_i  (z_mag),
    .sign_i (neg_q),
    .bf16_o (packed_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      iter_q   <= '0;
      neg_q    <= 1'b0;
      abs_q    <= '0;
      result_q <= 16'h0000;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          if (start) begin
            neg_q <= a[INPUTOUTBIT-1];
            abs_q <= abs_a;
            if (!a_legal || (mode_e'(mode) == MODE_RSVD) ||
                ((mode_e'(mode) != MODE_ATAN) && !a_small)) begin
              result_q <= BF16_NAN;
              error_q  <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else if (mode_e'(mode) == MODE_ATAN) begin
              busy_q  <= 1'b1;
              state_q <= ST_LOAD;
            end else begin
              result_q <= small_res;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          x_q     <= XY_ONE;
          y_q     <= $signed({{(XYW-INPUTOUTBIT){1'b0}}, abs_q} << ITER);
          z_q     <= '0;
          iter_q  <= '0;
          state_q <= ST_ITER;
        end
        ST_ITER: begin
          // Both shifts read the pre-update x and y.
          if (!y_q[XYW-1]) begin
            x_q <= x_q + (y_q >>> iter_q);
            y_q <= y_q - (x_q >>> iter_q);
            z_q <= z_q + tab_val;
          end else begin
            x_q <= x_q - (y_q >>> iter_q);
            y_q <= y_q + (x_q >>> iter_q);
            z_q <= z_q - tab_val;
          end
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'(ITER - 1)) state_q <= ST_PACK;
        end
        ST_PACK: begin
          result_q <= packed_res;
          error_q  <= 1'b0;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_q;
  assign error  = error_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_trig_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_trig_unit
//  Description : Directed self-checking bench for inv_trig_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_trig_unit;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         mode  = 2'd0;
  logic signed [15:0] a     = 16'sd0;
  logic [15:0]        result;
  logic               error, done, busy;

  int checks = 0;
  int errors = 0;

  inv_trig_unit #(
    .ITER     (12),
    .ANG_FRAC (10)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .result (result),
    .error  (error),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Raise start and return 1 ns after the edge that samples it.
  task automatic launch(input logic [1:0] m, input logic signed [15:0] v);
    mode  = m;
    a     = v;
    start = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drop_start;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Edge count (after the sampling edge) at which done first appears; 0 on timeout.
  task automatic run_to_done(input int limit, output int n_edges,
                             output int n_busy, output int n_overlap);
    n_edges = 0; n_busy = 0; n_overlap = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (busy) n_busy++;
      if (busy && done) n_overlap++;
      if (done) begin
        n_edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_small(input logic [1:0] m, input string tag);
    logic signed [15:0] av [3];
    logic [15:0]        ex [3];
    av = '{-16'sd1, 16'sd0, 16'sd1};
    if (m == 2'd0) ex = '{16'hC2B4, 16'h0000, 16'h42B4};
    else           ex = '{16'h4334, 16'h42B4, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      launch(m, av[i]);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done a=%0d: got %b expected 1", tag, av[i], done); end
      checks++; if (result !== ex[i]) begin errors++; $display("FAIL %s_result a=%0d: got %h expected %h", tag, av[i], result, ex[i]); end
      checks++; if (error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_flags a=%0d: got err=%b busy=%b expected 0 0", tag, av[i], error, busy); end
      drop_start;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_idle a=%0d: got done=%b expected 0", tag, av[i], done); end
    end
    // asin/acos undefined at |a| = 2 ; reserved mode uses a legal operand
    if (m == 2'd0) launch(2'd0, 16'sd2);
    else           launch(2'd3, 16'sd0);
    checks++; if (result !== 16'hFFC0) begin errors++; $display("FAIL %s_nan_result: got %h expected ffc0", tag, result); end
    checks++; if (error !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL %s_nan_flags: got err=%b done=%b expected 1 1", tag, error, done); end
    drop_start;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL %s_nan_clear: got err=%b expected 0", tag, error); end
  endtask

  task automatic test_reset_mid_atan;
    int ne, nb, no;
    launch(2'd2, 16'sd3);
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({result, error, done, busy} !== 19'd0) begin errors++; $display("FAIL midrst_outputs: got result=%h err=%b done=%b busy=%b expected all 0", result, error, done, busy); end
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got done=%b busy=%b expected 0 0", done, busy); end
    launch(2'd2, 16'sd1);
    run_to_done(40, ne, nb, no);
    checks++; if (ne !== 14) begin errors++; $display("FAIL midrst_latency: got %0d expected 14", ne); end
    checks++; if (result !== 16'h4234) begin errors++; $display("FAIL midrst_atan1: got %h expected 4234", result); end
    drop_start;
  endtask

  task automatic test_atan;
    logic signed [15:0] av [4];
    logic [15:0]        ex [4];
    int ne, nb, no;
    av = '{16'sd2, -16'sd3, 16'sd999, 16'sd0};
    ex = '{16'h427E, 16'hC28F, 16'h42B4, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      launch(2'd2, av[i]);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL atan_load a=%0d: got busy=%b done=%b expected 1 0", av[i], busy, done); end
      // later operand/mode changes must not disturb the running operation
      a    = 16'sd7;
      mode = 2'd0;
      run_to_done(40, ne, nb, no);
      checks++; if (ne !== 14) begin errors++; $display("FAIL atan_latency a=%0d: got %0d expected 14", av[i], ne); end
      checks++; if (nb !== 13) begin errors++; $display("FAIL atan_busy a=%0d: got %0d expected 13", av[i], nb); end
      checks++; if (no !== 0) begin errors++; $display("FAIL atan_overlap a=%0d: got %0d expected 0", av[i], no); end
      checks++; if (result !== ex[i]) begin errors++; $display("FAIL atan_result a=%0d: got %h expected %h", av[i], result, ex[i]); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL atan_error a=%0d: got %b expected 0", av[i], error); end
      drop_start;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL atan_idle a=%0d: got %b expected 0", av[i], done); end
    end
  endtask

  task automatic test_range;
    logic signed [15:0] av [2];
    av = '{16'sd1000, -16'sd1000};
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 2; i++) begin
        launch(2'(m), av[i]);
        checks++; if (result !== 16'hFFC0) begin errors++; $display("FAIL range_result m=%0d a=%0d: got %h expected ffc0", m, av[i], result); end
        checks++; if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL range_flags m=%0d a=%0d: got err=%b done=%b busy=%b expected 1 1 0", m, av[i], error, done, busy); end
        drop_start;
      end
    end
  endtask

  task automatic test_handshake;
    int  rises, restarts, ne, nb, no, late;
    logic prev;
    rises = 0; restarts = 0; prev = 1'b0; late = 0;
    launch(2'd2, 16'sd1);
    for (int k = 0; k < 29; k++) begin
      @(posedge clk); #1;
      if (prev && busy) restarts++;
      if (done && !prev) rises++;
      prev = done;
    end
    checks++; if (rises !== 1) begin errors++; $display("FAIL hold_rises: got %0d expected 1", rises); end
    checks++; if (restarts !== 0) begin errors++; $display("FAIL hold_restart: got %0d expected 0", restarts); end
    checks++; if (done !== 1'b1 || result !== 16'h4234) begin errors++; $display("FAIL hold_done: got done=%b result=%h expected 1 4234", done, result); end
    drop_start;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", done); end

    launch(2'd2, 16'sd2);
    @(posedge clk); #1;
    start = 1'b0;
    run_to_done(40, ne, nb, no);
    checks++; if (ne == 0 || result !== 16'h427E) begin errors++; $display("FAIL drop_result: got edges=%0d result=%h expected done with 427e", ne, result); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done || busy) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL drop_single_done: got %0d extra active cycles expected 0", late); end
  endtask

  initial begin
    test_reset;
    test_small(2'd0, "asin");
    test_small(2'd1, "acos");
    test_reset_mid_atan;
    test_atan;
    test_range;
    test_handshake;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
